// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue stage: bundle layouts, state encoding, bubble constant
// and the operand bypass selector.
package alu_issue_pkg;

  localparam int unsigned ISS_XLEN  = 64;
  localparam int unsigned ISS_NREG  = 32;
  localparam int unsigned ISS_AW    = 5;
  localparam int unsigned ISS_INSTW = 32;
  localparam int unsigned ISS_TYPEW = 8;
  localparam int unsigned ISS_OPCW  = 8;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_STALL_RAW = 2'd1,
    ST_STALL_EX  = 2'd2
  } iss_state_e;

  // Decoded instruction as accepted from decode and held in the skid buffer
  typedef struct packed {
    logic [ISS_XLEN-1:0]  pc;
    logic [ISS_INSTW-1:0] inst;
    logic [ISS_TYPEW-1:0] itype;
    logic [ISS_OPCW-1:0]  opcode;
    logic                 rs1_ena;
    logic [ISS_AW-1:0]    rs1_addr;
    logic                 rs2_ena;
    logic [ISS_AW-1:0]    rs2_addr;
    logic                 use_pc;
    logic                 use_imm;
    logic [ISS_XLEN-1:0]  imm;
    logic                 rd_ena;
    logic [ISS_AW-1:0]    rd_addr;
  } dec_bundle_t;

  // Resolved bundle presented to the ALU
  typedef struct packed {
    logic                 valid;
    logic [ISS_XLEN-1:0]  pc;
    logic [ISS_INSTW-1:0] inst;
    logic [ISS_TYPEW-1:0] itype;
    logic [ISS_OPCW-1:0]  opcode;
    logic [ISS_XLEN-1:0]  op1;
    logic [ISS_XLEN-1:0]  op2;
    logic                 rd_ena;
    logic [ISS_AW-1:0]    rd_addr;
  } ex_bundle_t;

  localparam ex_bundle_t EX_BUBBLE = '0;

  // x0 reads as zero, then writeback bypass, then regfile
  function automatic logic [ISS_XLEN-1:0] sel_reg(
    input logic [ISS_AW-1:0]   addr,
    input logic [ISS_XLEN-1:0] rf_data,
    input logic                wb_ena,
    input logic [ISS_AW-1:0]   wb_addr,
    input logic [ISS_XLEN-1:0] wb_data
  );
    if (addr == '0)                       return '0;
    else if (wb_ena && (wb_addr == addr)) return wb_data;
    else                                  return rf_data;
  endfunction

endpackage

// File: rtl/alu_issue_stage_scoreboard.sv
// Register scoreboard: one pending bit per architectural register, with issue-set,
// writeback-clear and flush-kill updates plus two source lookups.
module issue_scoreboard
  import alu_issue_pkg::*;
#(
  parameter int unsigned NREG = ISS_NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_ena_i,
  input  logic [ISS_AW-1:0] set_addr_i,
  input  logic              clr_ena_i,
  input  logic [ISS_AW-1:0] clr_addr_i,
  input  logic              kill_ena_i,
  input  logic [ISS_AW-1:0] kill_addr_i,
  input  logic [ISS_AW-1:0] rs1_addr_i,
  input  logic [ISS_AW-1:0] rs2_addr_i,
  output logic              rs1_pend_c,
  output logic              rs2_pend_c
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Clears first so that a same-index issue set wins
  always_comb begin
    pending_d = pending_q;
    if (clr_ena_i)  pending_d[clr_addr_i]  = 1'b0;
    if (kill_ena_i) pending_d[kill_addr_i] = 1'b0;
    if (set_ena_i && (set_addr_i != '0)) pending_d[set_addr_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign rs1_pend_c = pending_q[rs1_addr_i];
  assign rs2_pend_c = pending_q[rs2_addr_i];

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: one-deep skid buffer, RAW hazard tracking, operand bypass and a
// registered bundle to the ALU that holds while a mul/div is in progress.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = ISS_XLEN,
  parameter int unsigned NREG = ISS_NREG
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_valid_i,
  output logic            dec_ready_o,
  input  logic [XLEN-1:0] dec_pc_i,
  input  logic [31:0]     dec_inst_i,
  input  logic [7:0]      dec_type_i,
  input  logic [7:0]      dec_opcode_i,
  input  logic            dec_rs1_ena_i,
  input  logic            dec_rs2_ena_i,
  input  logic [4:0]      dec_rs1_addr_i,
  input  logic [4:0]      dec_rs2_addr_i,
  input  logic            dec_use_pc_i,
  input  logic            dec_use_imm_i,
  input  logic [XLEN-1:0] dec_imm_i,
  input  logic            dec_rd_ena_i,
  input  logic [4:0]      dec_rd_addr_i,
  input  logic [XLEN-1:0] rf_rs1_data_i,
  input  logic [XLEN-1:0] rf_rs2_data_i,
  output logic [4:0]      rf_rs1_addr_o,
  output logic [4:0]      rf_rs2_addr_o,
  input  logic            wb_ena_i,
  input  logic [4:0]      wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            alu_busy_i,
  input  logic            flush_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [31:0]     ex_inst_o,
  output logic [7:0]      ex_type_o,
  output logic [7:0]      ex_opcode_o,
  output logic [XLEN-1:0] ex_op1_o,
  output logic [XLEN-1:0] ex_op2_o,
  output logic            ex_rd_ena_o,
  output logic [4:0]      ex_rd_addr_o
);

  iss_state_e  state_q, state_d;
  dec_bundle_t buf_q, buf_d;
  ex_bundle_t  ex_q, ex_d;
  dec_bundle_t dec_b, cand;

  logic            buf_full, cand_valid;
  logic            rs1_pend, rs2_pend, rs1_ready, rs2_ready, srcs_ready, issue;
  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    dec_b          = '0;
    dec_b.pc       = dec_pc_i;
    dec_b.inst     = dec_inst_i;
    dec_b.itype    = dec_type_i;
    dec_b.opcode   = dec_opcode_i;
    dec_b.rs1_ena  = dec_rs1_ena_i;
    dec_b.rs1_addr = dec_rs1_addr_i;
    dec_b.rs2_ena  = dec_rs2_ena_i;
    dec_b.rs2_addr = dec_rs2_addr_i;
    dec_b.use_pc   = dec_use_pc_i;
    dec_b.use_imm  = dec_use_imm_i;
    dec_b.imm      = dec_imm_i;
    dec_b.rd_ena   = dec_rd_ena_i;
    dec_b.rd_addr  = dec_rd_addr_i;
  end

  // The buffered bundle always has priority over the decode input
  assign buf_full   = (state_q != ST_EMPTY);
  assign cand       = buf_full ? buf_q : dec_b;
  assign cand_valid = buf_full | dec_valid_i;

  assign rf_rs1_addr_o = cand.rs1_addr;
  assign rf_rs2_addr_o = cand.rs2_addr;

  issue_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_ena_i   (issue & cand.rd_ena),
    .set_addr_i  (cand.rd_addr),
    .clr_ena_i   (wb_ena_i),
    .clr_addr_i  (wb_addr_i),
    .kill_ena_i  (flush_i & ex_q.valid & ex_q.rd_ena),
    .kill_addr_i (ex_q.rd_addr),
    .rs1_addr_i  (cand.rs1_addr),
    .rs2_addr_i  (cand.rs2_addr),
    .rs1_pend_c  (rs1_pend),
    .rs2_pend_c  (rs2_pend)
  );

  assign rs1_ready  = !cand.rs1_ena || (cand.rs1_addr == '0) || !rs1_pend ||
                      (wb_ena_i && (wb_addr_i == cand.rs1_addr));
  assign rs2_ready  = !cand.rs2_ena || (cand.rs2_addr == '0) || !rs2_pend ||
                      (wb_ena_i && (wb_addr_i == cand.rs2_addr));
  assign srcs_ready = rs1_ready & rs2_ready;
  assign issue      = cand_valid & srcs_ready & ~alu_busy_i & ~flush_i;

  assign dec_ready_o = ~buf_full | issue;

  assign rs1_val = sel_reg(cand.rs1_addr, rf_rs1_data_i, wb_ena_i, wb_addr_i, wb_data_i);
  assign rs2_val = sel_reg(cand.rs2_addr, rf_rs2_data_i, wb_ena_i, wb_addr_i, wb_data_i);

  // Buffer/state and ALU bundle next-state; flush dominates issue and accept
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    ex_d    = ex_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      ex_d    = EX_BUBBLE;
    end else begin
      if (issue) begin
        ex_d.valid   = 1'b1;
        ex_d.pc      = cand.pc;
        ex_d.inst    = cand.inst;
        ex_d.itype   = cand.itype;
        ex_d.opcode  = cand.opcode;
        ex_d.op1     = cand.use_pc  ? cand.pc  : rs1_val;
        ex_d.op2     = cand.use_imm ? cand.imm : rs2_val;
        ex_d.rd_ena  = cand.rd_ena;
        ex_d.rd_addr = cand.rd_addr;
      end else if (!alu_busy_i) begin
        ex_d = EX_BUBBLE;
      end

      if (buf_full) begin
        if (issue) begin
          // A refill behind the issuing bundle is re-evaluated next cycle
          if (dec_valid_i) begin
            buf_d   = dec_b;
            state_d = ST_STALL_RAW;
          end else begin
            state_d = ST_EMPTY;
          end
        end else begin
          state_d = srcs_ready ? ST_STALL_EX : ST_STALL_RAW;
        end
      end else if (dec_valid_i && !issue) begin
        buf_d   = dec_b;
        state_d = srcs_ready ? ST_STALL_EX : ST_STALL_RAW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      buf_q   <= '0;
      ex_q    <= EX_BUBBLE;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      ex_q    <= ex_d;
    end
  end

  assign ex_valid_o   = ex_q.valid;
  assign ex_pc_o      = ex_q.pc;
  assign ex_inst_o    = ex_q.inst;
  assign ex_type_o    = ex_q.itype;
  assign ex_opcode_o  = ex_q.opcode;
  assign ex_op1_o     = ex_q.op1;
  assign ex_op2_o     = ex_q.op2;
  assign ex_rd_ena_o  = ex_q.rd_ena;
  assign ex_rd_addr_o = ex_q.rd_addr;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: streaming, RAW stall with bypass,
// mul/div hold, scoreboard set/clear priority, flush and x0 handling.
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid_i, dec_ready_o;
  logic [63:0] dec_pc_i, dec_imm_i;
  logic [31:0] dec_inst_i;
  logic [7:0]  dec_type_i, dec_opcode_i;
  logic        dec_rs1_ena_i, dec_rs2_ena_i, dec_use_pc_i, dec_use_imm_i, dec_rd_ena_i;
  logic [4:0]  dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i;
  logic [63:0] rf_rs1_data_i, rf_rs2_data_i;
  logic [4:0]  rf_rs1_addr_o, rf_rs2_addr_o;
  logic        wb_ena_i;
  logic [4:0]  wb_addr_i;
  logic [63:0] wb_data_i;
  logic        alu_busy_i, flush_i;
  logic        ex_valid_o, ex_rd_ena_o;
  logic [63:0] ex_pc_o, ex_op1_o, ex_op2_o;
  logic [31:0] ex_inst_o;
  logic [7:0]  ex_type_o, ex_opcode_o;
  logic [4:0]  ex_rd_addr_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Regfile model: register n reads as 0x1000 + n
  assign rf_rs1_data_i = 64'h1000 + 64'(rf_rs1_addr_o);
  assign rf_rs2_data_i = 64'h1000 + 64'(rf_rs2_addr_o);

  alu_issue_stage dut (
    .clk(clk), .rst(rst),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_pc_i(dec_pc_i), .dec_inst_i(dec_inst_i), .dec_type_i(dec_type_i),
    .dec_opcode_i(dec_opcode_i),
    .dec_rs1_ena_i(dec_rs1_ena_i), .dec_rs2_ena_i(dec_rs2_ena_i),
    .dec_rs1_addr_i(dec_rs1_addr_i), .dec_rs2_addr_i(dec_rs2_addr_i),
    .dec_use_pc_i(dec_use_pc_i), .dec_use_imm_i(dec_use_imm_i), .dec_imm_i(dec_imm_i),
    .dec_rd_ena_i(dec_rd_ena_i), .dec_rd_addr_i(dec_rd_addr_i),
    .rf_rs1_data_i(rf_rs1_data_i), .rf_rs2_data_i(rf_rs2_data_i),
    .rf_rs1_addr_o(rf_rs1_addr_o), .rf_rs2_addr_o(rf_rs2_addr_o),
    .wb_ena_i(wb_ena_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .alu_busy_i(alu_busy_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_inst_o(ex_inst_o),
    .ex_type_o(ex_type_o), .ex_opcode_o(ex_opcode_o),
    .ex_op1_o(ex_op1_o), .ex_op2_o(ex_op2_o),
    .ex_rd_ena_o(ex_rd_ena_o), .ex_rd_addr_o(ex_rd_addr_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] pc, input logic [7:0] opc,
                       input logic r1e, input logic [4:0] r1,
                       input logic r2e, input logic [4:0] r2,
                       input logic upc, input logic uimm, input logic [63:0] imm,
                       input logic rde, input logic [4:0] rd);
    dec_valid_i    = 1'b1;
    dec_pc_i       = pc;
    dec_inst_i     = {16'hC0DE, pc[15:0]};
    dec_type_i     = ~opc;
    dec_opcode_i   = opc;
    dec_rs1_ena_i  = r1e;
    dec_rs1_addr_i = r1;
    dec_rs2_ena_i  = r2e;
    dec_rs2_addr_i = r2;
    dec_use_pc_i   = upc;
    dec_use_imm_i  = uimm;
    dec_imm_i      = imm;
    dec_rd_ena_i   = rde;
    dec_rd_addr_i  = rd;
  endtask

  initial begin
    rst = 1'b1;
    dec_valid_i = 1'b0; dec_pc_i = '0; dec_inst_i = '0; dec_type_i = '0; dec_opcode_i = '0;
    dec_rs1_ena_i = 1'b0; dec_rs2_ena_i = 1'b0; dec_rs1_addr_i = '0; dec_rs2_addr_i = '0;
    dec_use_pc_i = 1'b0; dec_use_imm_i = 1'b0; dec_imm_i = '0;
    dec_rd_ena_i = 1'b0; dec_rd_addr_i = '0;
    wb_ena_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    alu_busy_i = 1'b0; flush_i = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_ex_valid", 64'(ex_valid_o), 64'd0);
    chk("rst_ex_opcode", 64'(ex_opcode_o), 64'd0);
    chk("rst_ex_op1", ex_op1_o, 64'd0);
    chk("rst_ex_rd_ena", 64'(ex_rd_ena_o), 64'd0);
    chk("rst_dec_ready", 64'(dec_ready_o), 64'd1);
    chk("rst_state", 64'(dut.state_q), 64'(ST_EMPTY));
    chk("rst_pending", 64'(dut.u_scoreboard.pending_q), 64'd0);

    // 1. Independent stream: addi x1,x0,5 ; addi x2,x0,7
    drive(64'h100, 8'h11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 64'd5, 1'b1, 5'd1);
    #1 chk("t1_ready_a", 64'(dec_ready_o), 64'd1);
    tick();
    drive(64'h104, 8'h11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 64'd7, 1'b1, 5'd2);
    chk("t1_a_valid", 64'(ex_valid_o), 64'd1);
    chk("t1_a_pc", ex_pc_o, 64'h100);
    chk("t1_a_inst", 64'(ex_inst_o), 64'hC0DE0100);
    chk("t1_a_type", 64'(ex_type_o), 64'hEE);
    chk("t1_a_op1", ex_op1_o, 64'd0);
    chk("t1_a_op2", ex_op2_o, 64'd5);
    chk("t1_a_rd", 64'(ex_rd_addr_o), 64'd1);
    #1 chk("t1_ready_b", 64'(dec_ready_o), 64'd1);
    tick();
    dec_valid_i = 1'b0;
    chk("t1_b_pc", ex_pc_o, 64'h104);
    chk("t1_b_op2", ex_op2_o, 64'd7);
    chk("t1_b_rd", 64'(ex_rd_addr_o), 64'd2);
    chk("t1_pending", 64'(dut.u_scoreboard.pending_q), 64'h6);

    // 2. RAW stall: add x3,x1,x1 with x1 pending, released by writeback bypass
    drive(64'h108, 8'h22, 1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 1'b0, 64'd0, 1'b1, 5'd3);
    #1 chk("t2_ready_accept", 64'(dec_ready_o), 64'd1);
    tick();
    dec_valid_i = 1'b0;
    #1;
    chk("t2_state", 64'(dut.state_q), 64'(ST_STALL_RAW));
    chk("t2_bubble", 64'(ex_valid_o), 64'd0);
    chk("t2_ready_stalled", 64'(dec_ready_o), 64'd0);
    wb_ena_i = 1'b1; wb_addr_i = 5'd1; wb_data_i = 64'h2A;
    tick();
    wb_ena_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    chk("t2_valid", 64'(ex_valid_o), 64'd1);
    chk("t2_op1", ex_op1_o, 64'h2A);
    chk("t2_op2", ex_op2_o, 64'h2A);
    chk("t2_rd", 64'(ex_rd_addr_o), 64'd3);
    chk("t2_pending", 64'(dut.u_scoreboard.pending_q), 64'hC);

    // 3. mul x4,x5,x6 held for 10 busy cycles while add x7,x8,x9 waits
    drive(64'h10C, 8'h33, 1'b1, 5'd5, 1'b1, 5'd6, 1'b0, 1'b0, 64'd0, 1'b1, 5'd4);
    tick();
    chk("t3_mul_op1", ex_op1_o, 64'h1005);
    chk("t3_mul_op2", ex_op2_o, 64'h1006);
    alu_busy_i = 1'b1;
    drive(64'h110, 8'h44, 1'b1, 5'd8, 1'b1, 5'd9, 1'b0, 1'b0, 64'd0, 1'b1, 5'd7);
    for (int i = 0; i < 10; i++) begin
      tick();
      dec_valid_i = 1'b0;
      chk("t3_hold_opcode", 64'(ex_opcode_o), 64'h33);
      chk("t3_hold_valid", 64'(ex_valid_o), 64'd1);
    end
    chk("t3_hold_pc", ex_pc_o, 64'h10C);
    chk("t3_state", 64'(dut.state_q), 64'(ST_STALL_EX));
    chk("t3_ready_busy", 64'(dec_ready_o), 64'd0);
    alu_busy_i = 1'b0;
    #1 chk("t3_ready_drop", 64'(dec_ready_o), 64'd1);
    tick();
    chk("t3_add_opcode", 64'(ex_opcode_o), 64'h44);
    chk("t3_add_op1", ex_op1_o, 64'h1008);
    chk("t3_add_op2", ex_op2_o, 64'h1009);
    chk("t3_state_after", 64'(dut.state_q), 64'(ST_EMPTY));

    // 4. Issue writing x5 while writeback clears x5: set wins
    drive(64'h114, 8'h11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 64'd1, 1'b1, 5'd5);
    wb_ena_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 64'h55;
    tick();
    dec_valid_i = 1'b0;
    wb_ena_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    chk("t4_pending5", 64'(dut.u_scoreboard.pending_q[5]), 64'd1);

    // 5. Flush with a buffered bundle and an x6 writer in ex while busy
    drive(64'h118, 8'h11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 64'd9, 1'b1, 5'd6);
    tick();
    chk("t5_pending6_set", 64'(dut.u_scoreboard.pending_q[6]), 64'd1);
    alu_busy_i = 1'b1;
    drive(64'h11C, 8'h44, 1'b1, 5'd11, 1'b1, 5'd12, 1'b0, 1'b0, 64'd0, 1'b1, 5'd10);
    tick();
    dec_valid_i = 1'b0;
    chk("t5_buffered", 64'(dut.state_q), 64'(ST_STALL_EX));
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t5_ex_valid", 64'(ex_valid_o), 64'd0);
    chk("t5_ex_opcode", 64'(ex_opcode_o), 64'd0);
    chk("t5_ex_rd_ena", 64'(ex_rd_ena_o), 64'd0);
    chk("t5_state", 64'(dut.state_q), 64'(ST_EMPTY));
    chk("t5_pending", 64'(dut.u_scoreboard.pending_q), 64'hBC);
    alu_busy_i = 1'b0;
    #1 chk("t5_ready", 64'(dec_ready_o), 64'd1);

    // 6. x0 rules: write to x0 is ignored; read of x0 ignores wb to x0
    drive(64'h120, 8'h11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 64'd4, 1'b1, 5'd0);
    tick();
    chk("t6_x0_write_rd", 64'(ex_rd_addr_o), 64'd0);
    chk("t6_x0_pending", 64'(dut.u_scoreboard.pending_q), 64'hBC);
    drive(64'h124, 8'h11, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 64'd3, 1'b1, 5'd9);
    wb_ena_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 64'hFF;
    tick();
    wb_ena_i = 1'b0; wb_data_i = '0;
    chk("t6_x0_read_op1", ex_op1_o, 64'd0);
    chk("t6_x0_read_op2", ex_op2_o, 64'd3);
    drive(64'h200, 8'h55, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 64'h10, 1'b0, 5'd0);
    tick();
    dec_valid_i = 1'b0;
    chk("t6_use_pc_op1", ex_op1_o, 64'h200);
    chk("t6_use_pc_op2", ex_op2_o, 64'h10);
    tick();
    chk("t6_idle_bubble", 64'(ex_valid_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
